// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer: entry record and ROB geometry.
package rob_pkg;

  localparam int REGID_W   = 6;
  localparam int NUM_PREGS = 34;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_PTR_W = 4;

  typedef struct packed {
    logic               valid;
    logic               done;
    logic               has_dest;
    logic [REGID_W-1:0] reg_id;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-around pointer with increment enable, synchronous clear and asynchronous reset.
module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  // Wrap comes for free from the W-bit adder since depth is a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates on dispatch, marks done on CDB, retires from head
// and emits spaced busy-bit clear pulses toward the scoreboard.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int PTR_W = ROB_PTR_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               SYS,
  input  logic               enable_IN_DISP,
  input  logic [REGID_W-1:0] RegID_IN_DISP,
  input  logic               hasDest_IN_DISP,
  output logic [PTR_W-1:0]   ROBTag_OUT,
  output logic               full_OUT,
  output logic               empty_OUT,
  output logic [PTR_W:0]     count_OUT,
  input  logic               enable_IN_CDB,
  input  logic [PTR_W-1:0]   ROBTag_IN_CDB,
  output logic [REGID_W-1:0] RegID_OUT_RRAT,
  output logic               enable_OUT_RRAT
);

  rob_entry_t         entries_q [DEPTH];
  rob_entry_t         entries_d [DEPTH];
  logic [PTR_W:0]     count_q, count_d;
  logic               rrat_en_q, rrat_en_d;
  logic [REGID_W-1:0] rrat_reg_q, rrat_reg_d;

  logic [PTR_W-1:0]   head_ptr, tail_ptr;
  rob_entry_t         head_e;
  logic               disp_fire, retire_fire, cdb_hit;

  assign full_OUT   = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_OUT  = (count_q == '0);
  assign count_OUT  = count_q;
  assign ROBTag_OUT = tail_ptr;
  assign RegID_OUT_RRAT  = rrat_reg_q;
  assign enable_OUT_RRAT = rrat_en_q;

  assign head_e    = entries_q[head_ptr];
  assign disp_fire = enable_IN_DISP && !full_OUT;
  // A destination retire waits while the previous pulse is still high so each clear is a new edge.
  assign retire_fire = head_e.valid && head_e.done && !(head_e.has_dest && rrat_en_q);
  assign cdb_hit = enable_IN_CDB && entries_q[ROBTag_IN_CDB].valid
                   && !(disp_fire && (ROBTag_IN_CDB == tail_ptr));

  rob_ptr #(.W(PTR_W)) u_head (
    .clk (CLK),
    .rst (RESET),
    .clr (SYS),
    .inc (retire_fire),
    .ptr (head_ptr)
  );

  rob_ptr #(.W(PTR_W)) u_tail (
    .clk (CLK),
    .rst (RESET),
    .clr (SYS),
    .inc (disp_fire),
    .ptr (tail_ptr)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    count_d    = count_q;
    rrat_en_d  = 1'b0;
    rrat_reg_d = rrat_reg_q;
    if (SYS) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
      count_d = '0;
    end else begin
      if (cdb_hit) begin
        entries_d[ROBTag_IN_CDB].done = 1'b1;
      end
      if (retire_fire) begin
        entries_d[head_ptr].valid = 1'b0;
        if (head_e.has_dest) begin
          rrat_en_d  = 1'b1;
          rrat_reg_d = head_e.reg_id;
        end
      end
      // Head and tail only coincide when empty (no retire) or full (no dispatch).
      if (disp_fire) begin
        entries_d[tail_ptr].valid    = 1'b1;
        entries_d[tail_ptr].done     = 1'b0;
        entries_d[tail_ptr].has_dest = hasDest_IN_DISP;
        entries_d[tail_ptr].reg_id   = RegID_IN_DISP;
      end
      case ({disp_fire, retire_fire})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        entries_q[gi] <= '0;
      end else begin
        entries_q[gi] <= entries_d[gi];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q    <= '0;
      rrat_en_q  <= 1'b0;
      rrat_reg_q <= '0;
    end else begin
      count_q    <= count_d;
      rrat_en_q  <= rrat_en_d;
      rrat_reg_q <= rrat_reg_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench: vector table plus hand sequences; clear pulses checked against a queue.
module tb_reorder_buffer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SYS = 1'b0;
  logic       enable_IN_DISP = 1'b0;
  logic [5:0] RegID_IN_DISP = '0;
  logic       hasDest_IN_DISP = 1'b0;
  logic [3:0] ROBTag_OUT;
  logic       full_OUT;
  logic       empty_OUT;
  logic [4:0] count_OUT;
  logic       enable_IN_CDB = 1'b0;
  logic [3:0] ROBTag_IN_CDB = '0;
  logic [5:0] RegID_OUT_RRAT;
  logic       enable_OUT_RRAT;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic prev_en = 1'b0;

  reorder_buffer dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .SYS             (SYS),
    .enable_IN_DISP  (enable_IN_DISP),
    .RegID_IN_DISP   (RegID_IN_DISP),
    .hasDest_IN_DISP (hasDest_IN_DISP),
    .ROBTag_OUT      (ROBTag_OUT),
    .full_OUT        (full_OUT),
    .empty_OUT       (empty_OUT),
    .count_OUT       (count_OUT),
    .enable_IN_CDB   (enable_IN_CDB),
    .ROBTag_IN_CDB   (ROBTag_IN_CDB),
    .RegID_OUT_RRAT  (RegID_OUT_RRAT),
    .enable_OUT_RRAT (enable_OUT_RRAT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       disp;
    logic       has;
    logic [5:0] rid;
    logic       cdb;
    logic [3:0] tag;
    int         ecount;
    int         etag;
    int         een;
    int         ereg;
  } vec_t;

  vec_t tbl [33];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic disp, input logic has, input logic [5:0] rid,
                     input logic cdb, input logic [3:0] tag, input logic sys);
    enable_IN_DISP  = disp;
    hasDest_IN_DISP = has;
    RegID_IN_DISP   = rid;
    enable_IN_CDB   = cdb;
    ROBTag_IN_CDB   = tag;
    SYS             = sys;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 1'b0);
  endtask

  // Every clear pulse must be a fresh edge and match the next expected register in program order.
  always @(negedge CLK) begin
    if (RESET) begin
      prev_en = 1'b0;
    end else begin
      if (enable_OUT_RRAT) begin
        checks++;
        if (prev_en) begin
          errors++;
          $display("FAIL rrat_gap: got high two cycles running expected a low cycle between pulses");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rrat_unexpected: got pulse reg %0d expected none", RegID_OUT_RRAT);
        end else begin
          automatic int e = exp_q.pop_front();
          if (RegID_OUT_RRAT !== 6'(e)) begin
            errors++;
            $display("FAIL rrat_reg: got %0d expected %0d", RegID_OUT_RRAT, e);
          end else begin
            $display("pulse reg=%0d t=%0t", RegID_OUT_RRAT, $time);
          end
        end
      end
      prev_en = enable_OUT_RRAT;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // disp has rid cdb tag | count tag en reg
    tbl[0]  = '{1,1,12,0,0, 1,1,0,0};
    tbl[1]  = '{0,0,0, 1,0, 1,1,0,0};
    tbl[2]  = '{0,0,0, 0,0, 0,1,1,12};
    tbl[3]  = '{0,0,0, 0,0, 0,1,0,12};
    tbl[4]  = '{1,1,3, 0,0, 1,2,0,12};
    tbl[5]  = '{1,1,4, 0,0, 2,3,0,12};
    tbl[6]  = '{1,1,5, 0,0, 3,4,0,12};
    tbl[7]  = '{0,0,0, 1,3, 3,4,0,12};
    tbl[8]  = '{0,0,0, 1,2, 3,4,0,12};
    tbl[9]  = '{0,0,0, 1,1, 3,4,0,12};
    tbl[10] = '{0,0,0, 0,0, 2,4,1,3};
    tbl[11] = '{0,0,0, 0,0, 2,4,0,3};
    tbl[12] = '{0,0,0, 0,0, 1,4,1,4};
    tbl[13] = '{0,0,0, 0,0, 1,4,0,4};
    tbl[14] = '{0,0,0, 0,0, 0,4,1,5};
    tbl[15] = '{0,0,0, 0,0, 0,4,0,5};
    tbl[16] = '{1,0,9, 0,0, 1,5,0,5};
    tbl[17] = '{1,1,7, 1,4, 2,6,0,5};
    tbl[18] = '{0,0,0, 1,5, 1,6,0,5};
    tbl[19] = '{0,0,0, 1,10, 0,6,1,7};
    tbl[20] = '{0,0,0, 0,0, 0,6,0,7};
    tbl[21] = '{0,0,0, 1,6, 0,6,0,7};
    tbl[22] = '{1,1,20,0,0, 1,7,0,7};
    tbl[23] = '{0,0,0, 0,0, 1,7,0,7};
    tbl[24] = '{0,0,0, 0,0, 1,7,0,7};
    tbl[25] = '{1,1,21,1,7, 2,8,0,7};
    tbl[26] = '{0,0,0, 0,0, 2,8,0,7};
    tbl[27] = '{0,0,0, 1,6, 2,8,0,7};
    tbl[28] = '{0,0,0, 0,0, 1,8,1,20};
    tbl[29] = '{0,0,0, 0,0, 1,8,0,20};
    tbl[30] = '{0,0,0, 1,7, 1,8,0,20};
    tbl[31] = '{0,0,0, 0,0, 0,8,1,21};
    tbl[32] = '{0,0,0, 0,0, 0,8,0,21};

    // Power-on reset state
    #3;
    chk("reset_count", int'(count_OUT), 0);
    chk("reset_empty", int'(empty_OUT), 1);
    chk("reset_full", int'(full_OUT), 0);
    chk("reset_tag", int'(ROBTag_OUT), 0);
    chk("reset_en", int'(enable_OUT_RRAT), 0);
    @(posedge CLK); @(posedge CLK); #2;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Basic flow, out-of-order completion, mixed destinations, ignored CDB tags
    for (int i = 0; i < 33; i++) begin
      if (tbl[i].disp && tbl[i].has) exp_q.push_back(int'(tbl[i].rid));
      cyc(tbl[i].disp, tbl[i].has, tbl[i].rid, tbl[i].cdb, tbl[i].tag, 1'b0);
      $display("vec %0d: count=%0d tag=%0d en=%0d reg=%0d", i, count_OUT, ROBTag_OUT,
               enable_OUT_RRAT, RegID_OUT_RRAT);
      chk($sformatf("vec%0d_count", i), int'(count_OUT), tbl[i].ecount);
      chk($sformatf("vec%0d_tag", i), int'(ROBTag_OUT), tbl[i].etag);
      chk($sformatf("vec%0d_en", i), int'(enable_OUT_RRAT), tbl[i].een);
      chk($sformatf("vec%0d_reg", i), int'(RegID_OUT_RRAT), tbl[i].ereg);
      chk($sformatf("vec%0d_empty", i), int'(empty_OUT), int'(tbl[i].ecount == 0));
    end

    // Asynchronous reset mid-stream with 5 entries valid
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 6'(28 + i), 1'b0, 4'd0, 1'b0);
    chk("prereset_count", int'(count_OUT), 5);
    enable_IN_DISP = 1'b0;
    #1 RESET = 1'b1;
    #1;
    $display("async reset asserted t=%0t", $time);
    chk("midreset_count", int'(count_OUT), 0);
    chk("midreset_empty", int'(empty_OUT), 1);
    chk("midreset_en", int'(enable_OUT_RRAT), 0);
    chk("midreset_tag", int'(ROBTag_OUT), 0);
    chk("midreset_reg", int'(RegID_OUT_RRAT), 0);
    exp_q.delete();
    idle();
    @(posedge CLK); #2;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Fill to full; entry 1 has no destination
    for (int i = 0; i < 16; i++) begin
      if (i != 1) exp_q.push_back(i);
      cyc(1'b1, logic'(i != 1), 6'(i), 1'b0, 4'd0, 1'b0);
    end
    $display("filled: count=%0d full=%0d tag=%0d", count_OUT, full_OUT, ROBTag_OUT);
    chk("full_count", int'(count_OUT), 16);
    chk("full_flag", int'(full_OUT), 1);
    chk("full_tag", int'(ROBTag_OUT), 0);
    cyc(1'b1, 1'b1, 6'd33, 1'b0, 4'd0, 1'b0);
    chk("drop_count", int'(count_OUT), 16);
    chk("drop_full", int'(full_OUT), 1);
    chk("drop_tag", int'(ROBTag_OUT), 0);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 4'd0, 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 4'd1, 1'b0);
    chk("wrap_retire_count", int'(count_OUT), 15);
    chk("wrap_retire_full", int'(full_OUT), 0);
    chk("wrap_tag", int'(ROBTag_OUT), 0);
    exp_q.push_back(16);
    cyc(1'b1, 1'b1, 6'd16, 1'b1, 4'd2, 1'b0);
    $display("dispatch+retire: count=%0d tag=%0d", count_OUT, ROBTag_OUT);
    chk("simul_count", int'(count_OUT), 15);
    chk("simul_tag", int'(ROBTag_OUT), 1);
    for (int t = 3; t < 16; t++) cyc(1'b0, 1'b0, 6'd0, 1'b1, 4'(t), 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 40; i++) idle();
    chk("drain_count", int'(count_OUT), 0);
    chk("drain_pending", exp_q.size(), 0);

    // SYS flush with a pulse in flight
    exp_q.push_back(20);
    for (int r = 20; r < 26; r++) cyc(1'b1, 1'b1, 6'(r), 1'b0, 4'd0, 1'b0);
    chk("sys_pre_count", int'(count_OUT), 6);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 4'd1, 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 4'd2, 1'b0);
    chk("sys_inflight_en", int'(enable_OUT_RRAT), 1);
    chk("sys_inflight_count", int'(count_OUT), 5);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 4'd3, 1'b1);
    $display("sys flush: count=%0d en=%0d tag=%0d", count_OUT, enable_OUT_RRAT, ROBTag_OUT);
    chk("sys_count", int'(count_OUT), 0);
    chk("sys_en", int'(enable_OUT_RRAT), 0);
    chk("sys_empty", int'(empty_OUT), 1);
    chk("sys_tag", int'(ROBTag_OUT), 0);
    chk("sys_reg_hold", int'(RegID_OUT_RRAT), 20);
    idle();
    exp_q.push_back(30);
    cyc(1'b1, 1'b1, 6'd30, 1'b0, 4'd0, 1'b0);
    chk("post_sys_count", int'(count_OUT), 1);
    chk("post_sys_tag", int'(ROBTag_OUT), 1);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 4'd0, 1'b0);
    idle();
    chk("post_sys_en", int'(enable_OUT_RRAT), 1);
    chk("post_sys_reg", int'(RegID_OUT_RRAT), 30);
    for (int i = 0; i < 5; i++) idle();
    chk("final_pending", exp_q.size(), 0);
    chk("final_empty", int'(empty_OUT), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
